ram_access_arbiter: RTL

Sequencer and two-port arbiter for the processor's byte-lane data RAM: four 8-bit `MemoryRAM` lane instances (lane k holds bits [8k+7:8k]) behind a single 32-bit word-addressed store. Two requesters share the RAM: port A (processor load/store unit) and port B (loader/debug). The block grants them round-robin, runs each access as a fixed four-state sequence, and drives per-lane enable/write strobes for byte, half and word stores. It aligns and sign/zero-extends read data and rejects misaligned or invalid accesses.

---
 rtl/ram_access_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the four-lane byte RAM.
// Each access runs IDLE -> ACCESS -> WAIT -> RESP. Rejected accesses go IDLE -> RESP.
module ram_access_arbiter #(
  parameter int unsigned RAM_ADDR_BITS = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       AReq,
  input  logic                       AWrite,
  input  logic [RAM_ADDR_BITS+1:0]   AAddr,
  input  logic [1:0]                 ASize,
  input  logic                       AUnsigned,
  input  logic [31:0]                AWData,
  output logic                       AAck,
  output logic                       AErr,
  output logic [31:0]                ARData,
  input  logic                       BReq,
  input  logic                       BWrite,
  input  logic [RAM_ADDR_BITS+1:0]   BAddr,
  input  logic [1:0]                 BSize,
  input  logic                       BUnsigned,
  input  logic [31:0]                BWData,
  output logic                       BAck,
  output logic                       BErr,
  output logic [31:0]                BRData,
  output logic [3:0]                 LaneEnable,
  output logic [3:0]                 LaneWrite,
  output logic [RAM_ADDR_BITS-1:0]   LaneAddress,
  output logic [31:0]                LaneData,
  input  logic [31:0]                LaneQ,
  output logic                       Busy
);

  localparam int unsigned BYTE_ADDR_W = RAM_ADDR_BITS + 2;
  localparam logic [1:0]  SZ_BYTE     = 2'b00;
  localparam logic [1:0]  SZ_HALF     = 2'b01;
  localparam logic [1:0]  SZ_WORD     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << ofs;
      SZ_HALF: lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Invalid size or an offset not aligned to the access size.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] ofs);
    bad_access = (size == 2'b11) ||
                 ((size == SZ_HALF) && ofs[0]) ||
                 ((size == SZ_WORD) && (ofs != 2'b00));
  endfunction

  // Store data replicated so every enabled lane sees its byte.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: replicate = {4{wd[7:0]}};
      SZ_HALF: replicate = {2{wd[15:0]}};
      SZ_WORD: replicate = wd;
      default: replicate = 32'h0;
    endcase
  endfunction

  // Pick the addressed bytes out of the lane word and extend to 32 bits.
  function automatic logic [31:0] format_load(input logic [1:0] size, input logic [1:0] ofs,
                                              input logic uns, input logic [31:0] q);
    logic [7:0]  b;
    logic [15:0] h;
    b = q[{ofs, 3'b000} +: 8];
    h = ofs[1] ? q[31:16] : q[15:0];
    case (size)
      SZ_BYTE: format_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: format_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: format_load = q;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic                     last_b_q, last_b_d;
  logic                     port_b_q, port_b_d;
  logic                     write_q, write_d;
  logic [1:0]               ofs_q, ofs_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic                     a_ack_q, a_ack_d;
  logic                     a_err_q, a_err_d;
  logic [31:0]              a_rdata_q, a_rdata_d;
  logic                     b_ack_q, b_ack_d;
  logic                     b_err_q, b_err_d;
  logic [31:0]              b_rdata_q, b_rdata_d;
  logic [3:0]               lane_en_q, lane_en_d;
  logic [3:0]               lane_we_q, lane_we_d;
  logic [RAM_ADDR_BITS-1:0] lane_addr_q, lane_addr_d;
  logic [31:0]              lane_data_q, lane_data_d;
  logic                     busy_q, busy_d;

  logic                     grant_b;
  logic                     sel_write;
  logic [BYTE_ADDR_W-1:0]   sel_addr;
  logic [1:0]               sel_size;
  logic                     sel_uns;
  logic [31:0]              sel_wdata;
  logic [3:0]               sel_mask;
  logic [31:0]              load_val;

  // Round-robin winner and its request fields.
  always_comb begin
    grant_b   = BReq && (!AReq || !last_b_q);
    sel_write = grant_b ? BWrite    : AWrite;
    sel_addr  = grant_b ? BAddr     : AAddr;
    sel_size  = grant_b ? BSize     : ASize;
    sel_uns   = grant_b ? BUnsigned : AUnsigned;
    sel_wdata = grant_b ? BWData    : AWData;
    sel_mask  = lane_mask(sel_size, sel_addr[1:0]);
    load_val  = format_load(size_q, ofs_q, uns_q, LaneQ);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    port_b_d    = port_b_q;
    write_d     = write_q;
    ofs_d       = ofs_q;
    size_d      = size_q;
    uns_d       = uns_q;
    a_ack_d     = 1'b0;
    a_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_ack_d     = 1'b0;
    b_err_d     = 1'b0;
    b_rdata_d   = b_rdata_q;
    lane_en_d   = 4'b0000;
    lane_we_d   = 4'b0000;
    lane_addr_d = lane_addr_q;
    lane_data_d = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (AReq || BReq) begin
          last_b_d = grant_b;
          port_b_d = grant_b;
          write_d  = sel_write;
          ofs_d    = sel_addr[1:0];
          size_d   = sel_size;
          uns_d    = sel_uns;
          if (bad_access(sel_size, sel_addr[1:0])) begin
            state_d = S_RESP;
            if (grant_b) begin
              b_ack_d   = 1'b1;
              b_err_d   = 1'b1;
              b_rdata_d = 32'h0;
            end else begin
              a_ack_d   = 1'b1;
              a_err_d   = 1'b1;
              a_rdata_d = 32'h0;
            end
          end else begin
            state_d     = S_ACCESS;
            lane_en_d   = sel_mask;
            lane_we_d   = sel_write ? sel_mask : 4'b0000;
            lane_addr_d = sel_addr[BYTE_ADDR_W-1:2];
            lane_data_d = replicate(sel_size, sel_wdata);
          end
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_RESP;
        if (port_b_q) begin
          b_ack_d = 1'b1;
          if (!write_q) b_rdata_d = load_val;
        end else begin
          a_ack_d = 1'b1;
          if (!write_q) a_rdata_d = load_val;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything and points last grant at B.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;
      port_b_q    <= 1'b0;
      write_q     <= 1'b0;
      ofs_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      a_rdata_q   <= 32'h0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      b_rdata_q   <= 32'h0;
      lane_en_q   <= 4'b0000;
      lane_we_q   <= 4'b0000;
      lane_addr_q <= '0;
      lane_data_q <= 32'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      port_b_q    <= port_b_d;
      write_q     <= write_d;
      ofs_q       <= ofs_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      a_ack_q     <= a_ack_d;
      a_err_q     <= a_err_d;
      a_rdata_q   <= a_rdata_d;
      b_ack_q     <= b_ack_d;
      b_err_q     <= b_err_d;
      b_rdata_q   <= b_rdata_d;
      lane_en_q   <= lane_en_d;
      lane_we_q   <= lane_we_d;
      lane_addr_q <= lane_addr_d;
      lane_data_q <= lane_data_d;
      busy_q      <= busy_d;
    end
  end

  assign AAck        = a_ack_q;
  assign AErr        = a_err_q;
  assign ARData      = a_rdata_q;
  assign BAck        = b_ack_q;
  assign BErr        = b_err_q;
  assign BRData      = b_rdata_q;
  assign LaneEnable  = lane_en_q;
  assign LaneWrite   = lane_we_q;
  assign LaneAddress = lane_addr_q;
  assign LaneData    = lane_data_q;
  assign Busy        = busy_q;

endmodule
